// File: rtl/cafe_dispenser_param_if.sv
// cafe_dispenser_param_if: panel/sensor inputs and actuator/status outputs of the dispenser
interface cafe_dispenser_param_if #(parameter int CW = 8);
    logic            start;
    logic [1:0]      sel;
    logic            s_level;
    logic            s_temp;
    logic            s_cup;
    logic            abort;
    logic            clr_fault;
    logic [1:0]      M;
    logic            G;
    logic            C;
    logic            V;
    logic            busy;
    logic            done;
    logic            fault;
    logic [2:0]      fault_code;
    logic [CW-1:0]   cups;

    modport master (
        output start, sel, s_level, s_temp, s_cup, abort, clr_fault,
        input  M, G, C, V, busy, done, fault, fault_code, cups
    );

    modport slave (
        input  start, sel, s_level, s_temp, s_cup, abort, clr_fault,
        output M, G, C, V, busy, done, fault, fault_code, cups
    );
endinterface

// File: rtl/cafe_dispenser_param.sv
// cafe_dispenser_param: multi-recipe beverage dispenser FSM with stage timeouts, fault latch and cup counter
module cafe_dispenser_param #(
    parameter int TW        = 16,
    parameter int T_GRIND   = 100,
    parameter int T_MILK    = 200,
    parameter int T_TIMEOUT = 1000,
    parameter int CW        = 8
) (
    input logic clk,
    input logic rst,
    cafe_dispenser_param_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FILL, GRIND, HEAT, BREW, MILK, DONE, FAULT} state_t;

    localparam logic [TW-1:0] GRIND_END = TW'(T_GRIND - 1);
    localparam logic [TW-1:0] MILK_END  = TW'(T_MILK - 1);
    localparam logic [TW-1:0] WAIT_END  = TW'(T_TIMEOUT - 1);

    state_t        state;
    state_t        nxt;
    logic [TW-1:0] timer;
    logic [1:0]    sel_q;
    logic [1:0]    shots;
    logic [2:0]    code;
    logic [2:0]    nxt_code;
    logic [CW-1:0] cups;
    logic          active;

    // next state and fault code: abort beats clr_fault beats the stage rules
    always_comb begin
        nxt      = state;
        nxt_code = code;
        active   = state inside {FILL, GRIND, HEAT, BREW, MILK};
        if (active && bus.abort) begin
            nxt = IDLE;
        end else if (state == FAULT && bus.clr_fault) begin
            nxt      = IDLE;
            nxt_code = 3'd0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    nxt      = bus.sel == 2'd3 ? FAULT : FILL;
                    nxt_code = bus.sel == 2'd3 ? 3'd1 : code;
                end
                FILL: if (bus.s_level) nxt = GRIND;
                    else if (timer == WAIT_END) begin
                        nxt      = FAULT;
                        nxt_code = 3'd2;
                    end
                GRIND: if (timer == GRIND_END) nxt = HEAT;
                HEAT: if (bus.s_temp) nxt = BREW;
                    else if (timer == WAIT_END) begin
                        nxt      = FAULT;
                        nxt_code = 3'd3;
                    end
                BREW: if (bus.s_cup) nxt = (sel_q == 2'd1 && shots == 2'd0) ? HEAT :
                                           (sel_q == 2'd2) ? MILK : DONE;
                    else if (timer == WAIT_END) begin
                        nxt      = FAULT;
                        nxt_code = 3'd4;
                    end
                MILK: if (timer == MILK_END) nxt = DONE;
                DONE: nxt = IDLE;
                default: nxt = state;
            endcase
        end
    end

    // state, stage timer, latched recipe, shot count, fault code and saturating cup count
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            sel_q <= 2'd0;
            shots <= 2'd0;
            code  <= 3'd0;
            cups  <= '0;
        end else begin
            state <= nxt;
            code  <= nxt_code;
            timer <= nxt != state ? '0 : timer + TW'(1);
            if (state == IDLE && bus.start && bus.sel != 2'd3) begin
                sel_q <= bus.sel;
                shots <= 2'd0;
            end
            if (state == BREW && bus.s_cup) shots <= shots + 2'd1;
            if (state == DONE && cups != '1) cups <= cups + CW'(1);
        end
    end

    // Moore output decode from the state register only
    always_comb begin
        bus.M          = state == GRIND ? 2'b01 : state == MILK ? 2'b10 : 2'b00;
        bus.G          = state inside {HEAT, BREW, MILK};
        bus.C          = state == BREW;
        bus.V          = state == FILL;
        bus.busy       = !(state inside {IDLE, FAULT});
        bus.done       = state == DONE;
        bus.fault      = state == FAULT;
        bus.fault_code = code;
        bus.cups       = cups;
    end
endmodule

// File: tb/tb_cafe_dispenser_param.sv
// tb_cafe_dispenser_param: randomized brews checked by an event scoreboard against a recipe-level model
module tb_cafe_dispenser_param;
    localparam int TW = 16;
    localparam int TG = 4;
    localparam int TM = 3;
    localparam int TO = 8;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    localparam int K_DONE = 0;
    localparam int K_FAULT = 1;
    localparam int K_ABORT = 2;

    localparam int S_FILL = 0;
    localparam int S_GRIND = 1;
    localparam int S_HEAT = 2;
    localparam int S_BREW = 3;
    localparam int S_MILK = 4;
    localparam int S_DONE = 5;

    typedef struct packed {
        int kind;
        int code;
        int cups;
        int nv;
        int nm1;
        int nm2;
        int ng;
        int nc;
        int nbusy;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cafe_dispenser_param_if #(.CW(CW)) bus();

    cafe_dispenser_param #(
        .TW(TW), .T_GRIND(TG), .T_MILK(TM), .T_TIMEOUT(TO), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ev_t exp_q[$];
    int  seq[$];
    bit  trig[$];
    int  checks = 0;
    int  errors = 0;
    int  cups_m = 0;
    bit  mon_on = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // a sensor-waited stage: d idle cycles then the sensor, or a full timeout window
    task automatic push_wait(input int st, input int d, output bit timed_out);
        timed_out = d >= TO;
        for (int i = 0; i < (timed_out ? TO : d); i++) begin
            seq.push_back(st);
            trig.push_back(1'b0);
        end
        if (!timed_out) begin
            seq.push_back(st);
            trig.push_back(1'b1);
        end
    endtask

    task automatic push_fixed(input int st, input int n);
        for (int i = 0; i < n; i++) begin
            seq.push_back(st);
            trig.push_back(1'b0);
        end
    endtask

    function automatic int pick_d();
        int r;
        r = $urandom_range(0, 19);
        return r < 15 ? int'($urandom_range(0, 3)) : r < 18 ? TO - 1 : TO;
    endfunction

    // ab_at: -1 no abort, -2 random, otherwise index of the stage cycle that sees abort (or rst)
    task automatic run_txn(input int s, input int dl, input int dt, input int dc, input int ab_at, input bit use_rst);
        int  fc;
        int  stop;
        int  st;
        bit  to;
        ev_t e;
        seq.delete();
        trig.delete();
        fc = 0;
        if (s == 3) fc = 1;
        else begin
            push_wait(S_FILL, dl, to);
            if (to) fc = 2;
            if (fc == 0) push_fixed(S_GRIND, TG);
            for (int k = 0; k < (s == 1 ? 2 : 1); k++) begin
                if (fc == 0) begin
                    push_wait(S_HEAT, dt, to);
                    if (to) fc = 3;
                end
                if (fc == 0) begin
                    push_wait(S_BREW, dc, to);
                    if (to) fc = 4;
                end
            end
            if (fc == 0 && s == 2) push_fixed(S_MILK, TM);
            if (fc == 0) push_fixed(S_DONE, 1);
        end
        if (ab_at == -2)
            ab_at = (seq.size() > 1 && $urandom_range(0, 5) == 0) ?
                    int'($urandom_range(0, seq.size() - (fc != 0 ? 1 : 2))) : -1;
        stop = ab_at >= 0 ? ab_at + 1 : seq.size();
        e = '0;
        e.kind = ab_at >= 0 ? K_ABORT : fc != 0 ? K_FAULT : K_DONE;
        e.code = ab_at >= 0 ? 0 : fc;
        e.cups = use_rst ? 0 : cups_m;
        for (int i = 0; i < stop; i++) begin
            e.nv    += int'(seq[i] == S_FILL);
            e.nm1   += int'(seq[i] == S_GRIND);
            e.nm2   += int'(seq[i] == S_MILK);
            e.ng    += int'(seq[i] == S_HEAT || seq[i] == S_BREW || seq[i] == S_MILK);
            e.nc    += int'(seq[i] == S_BREW);
            e.nbusy += 1;
        end
        if (e.kind == K_DONE) cups_m = cups_m < CMAX ? cups_m + 1 : CMAX;
        if (use_rst) cups_m = 0;
        exp_q.push_back(e);
        bus.sel = 2'(s);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < stop; i++) begin
            st = seq[i];
            bus.sel = 2'($urandom);
            bus.s_level = st == S_FILL ? trig[i] : 1'($urandom);
            bus.s_temp = st == S_HEAT ? trig[i] : 1'($urandom);
            bus.s_cup = st == S_BREW ? trig[i] : 1'($urandom);
            bus.clr_fault = 1'($urandom);
            if (i == ab_at) begin
                if (use_rst) rst = 1'b1;
                else bus.abort = 1'b1;
            end
            tick;
            bus.abort = 1'b0;
            rst = 1'b0;
        end
        bus.s_level = 1'b0;
        bus.s_temp = 1'b0;
        bus.s_cup = 1'b0;
        bus.clr_fault = 1'b0;
        if (e.kind == K_FAULT) begin
            repeat ($urandom_range(0, 2)) begin
                bus.start = 1'($urandom);
                bus.abort = 1'($urandom);
                bus.sel = 2'($urandom);
                tick;
            end
            bus.start = 1'b0;
            bus.abort = 1'b0;
            bus.clr_fault = 1'b1;
            tick;
            bus.clr_fault = 1'b0;
            checks++;
            if (bus.fault !== 1'b0 || bus.busy !== 1'b0 || bus.fault_code !== 3'd0) begin
                errors++;
                $display("FAIL clr_fault: fault=%b busy=%b code=%0d, need 0 0 0", bus.fault, bus.busy, bus.fault_code);
            end
        end
        repeat ($urandom_range(0, 2)) tick;
    endtask

    // monitor: accumulate actuator activity, pop and compare on each done/fault/abort event
    initial begin
        int  av, am1, am2, ag, ac, ab, kind;
        bit  pb, pd, pf;
        ev_t a;
        ev_t e;
        av = 0; am1 = 0; am2 = 0; ag = 0; ac = 0; ab = 0;
        pb = 1'b0; pd = 1'b0; pf = 1'b0;
        wait (mon_on);
        forever begin
            @(negedge clk);
            av  += int'(bus.V);
            am1 += int'(bus.M == 2'b01);
            am2 += int'(bus.M == 2'b10);
            ag  += int'(bus.G);
            ac  += int'(bus.C);
            ab  += int'(bus.busy);
            kind = -1;
            if (bus.done) kind = K_DONE;
            else if (bus.fault && !pf) kind = K_FAULT;
            else if (!bus.busy && pb && !pd && !bus.fault) kind = K_ABORT;
            if (kind >= 0) begin
                a.kind = kind;
                a.code = int'(bus.fault_code);
                a.cups = int'(bus.cups);
                a.nv = av; a.nm1 = am1; a.nm2 = am2; a.ng = ag; a.nc = ac; a.nbusy = ab;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL event: unexpected kind=%0d code=%0d cups=%0d", kind, a.code, a.cups);
                end else begin
                    e = exp_q.pop_front();
                    if (a != e || {bus.M, bus.G, bus.C, bus.V} != 5'd0) begin
                        errors++;
                        $display("FAIL event: got kind=%0d code=%0d cups=%0d v=%0d m1=%0d m2=%0d g=%0d c=%0d busy=%0d act=%b, need kind=%0d code=%0d cups=%0d v=%0d m1=%0d m2=%0d g=%0d c=%0d busy=%0d act=00000",
                                 a.kind, a.code, a.cups, a.nv, a.nm1, a.nm2, a.ng, a.nc, a.nbusy,
                                 {bus.M, bus.G, bus.C, bus.V},
                                 e.kind, e.code, e.cups, e.nv, e.nm1, e.nm2, e.ng, e.nc, e.nbusy);
                    end
                end
                av = 0; am1 = 0; am2 = 0; ag = 0; ac = 0; ab = 0;
            end
            pb = bus.busy;
            pd = bus.done;
            pf = bus.fault;
        end
    end

    // stimulus: reset, directed recipe/boundary cases, random brews, saturation and mid-brew reset
    initial begin
        int s;
        bus.start = 1'b0;
        bus.sel = 2'd0;
        bus.s_level = 1'b0;
        bus.s_temp = 1'b0;
        bus.s_cup = 1'b0;
        bus.abort = 1'b0;
        bus.clr_fault = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if ({bus.M, bus.G, bus.C, bus.V, bus.busy, bus.done, bus.fault, bus.fault_code, bus.cups} !== '0) begin
            errors++;
            $display("FAIL reset: M=%b G=%b C=%b V=%b busy=%b done=%b fault=%b code=%0d cups=%0d, need all 0",
                     bus.M, bus.G, bus.C, bus.V, bus.busy, bus.done, bus.fault, bus.fault_code, bus.cups);
        end
        rst = 1'b0;
        mon_on = 1'b1;
        run_txn(0, 0, 0, 0, -1, 0);
        run_txn(1, 0, 0, 0, -1, 0);
        run_txn(2, 1, 2, 1, -1, 0);
        run_txn(0, TO, 0, 0, -1, 0);
        run_txn(3, 0, 0, 0, -1, 0);
        run_txn(0, 0, TO - 1, 0, -1, 0);
        run_txn(0, 0, 0, TO - 1, -1, 0);
        run_txn(0, TO - 1, 0, 0, -1, 0);
        run_txn(0, 0, 0, 0, 3, 0);
        run_txn(1, 0, TO, 0, -1, 0);
        run_txn(2, 0, 0, TO, -1, 0);
        for (int n = 0; n < 60; n++) begin
            s = $urandom_range(0, 9) == 0 ? 3 : int'($urandom_range(0, 2));
            run_txn(s, pick_d(), pick_d(), pick_d(), -2, 0);
        end
        checks++;
        if (int'(bus.cups) != cups_m) begin
            errors++;
            $display("FAIL cups_saturate: got %0d, need %0d", bus.cups, cups_m);
        end
        run_txn(2, 0, 0, 0, 2, 1);
        checks++;
        if (bus.cups !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_brew: cups=%0d busy=%b, need 0 0", bus.cups, bus.busy);
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d events still pending, need 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
